// File: rtl/vm_dispense_ctrl.sv
// vm_dispense_ctrl
// Sequences vend and change requests onto a single shared motor/hopper channel.
// Request pulses are queued in a 4-entry FIFO of {chg, prod[1:0]} entries. Jobs
// are run one at a time with a mtr_en / mtr_done handshake. The block keeps a
// stock count per product, turns a vend of a sold-out product into a refund, and
// optionally latches a fault when the motor runs too long.
//
// Optional feature: define VM_DISP_TIMEOUT_EN to build the motor timeout counter
// and the FAULT entry path. When the macro is undefined, PROD/CHG wait forever for
// mtr_done and fault is tied low.
//
// Ports
//   clk, reset_n            rising-edge clock, synchronous active-low reset
//   req_a/req_b/req_c       one-cycle vend pulses (A > B > C when several are high)
//   req_chg                 one-cycle change-return pulse
//   restock                 reload every stock counter with STOCK_INIT
//   fault_clr               leave FAULT and clear the fault flag
//   mtr_done                completion level from the motor driver
//   mtr_en, mtr_sel         motor run command and channel (00 A, 01 B, 10 C, 11 change)
//   busy                    FSM is not IDLE
//   q_full                  FIFO holds 4 entries
//   sold_out                bit i set when stock of product i is zero
//   drop_err                one-cycle pulse when a request (or part of one) is dropped
//   fault                   sticky motor timeout flag
//
// state   | meaning
// IDLE    | waiting for a queued job
// LOAD    | pop FIFO head into the job register, pick product/refund/nothing
// PROD    | motor runs on the product channel until mtr_done
// CHG     | motor runs on the change hopper until mtr_done
// RELEASE | motor off, wait for mtr_done to drop before the next command
// FAULT   | motor timed out; job discarded, queue kept, wait for fault_clr

module vm_dispense_ctrl #(
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned STOCK_INIT = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       req_c,
  input  logic       req_chg,
  input  logic       restock,
  input  logic       fault_clr,
  input  logic       mtr_done,
  output logic       mtr_en,
  output logic [1:0] mtr_sel,
  output logic       busy,
  output logic       q_full,
  output logic [2:0] sold_out,
  output logic       drop_err,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PROD, S_CHG, S_RELEASE, S_FAULT
  } state_t;

  localparam logic [STOCK_W-1:0] STOCK_LD = STOCK_W'(STOCK_INIT);

  state_t             state_q, state_d;
  logic [2:0]         fifo_q [4];
  logic [2:0]         fifo_d [4];
  logic [1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]         count_q, count_d;
  logic [2:0]         job_q, job_d;
  logic               chg_pend_q, chg_pend_d;
  logic [STOCK_W-1:0] stock_q [3];
  logic [STOCK_W-1:0] stock_d [3];
  logic               mtr_en_q, mtr_en_d;
  logic [1:0]         mtr_sel_q, mtr_sel_d;
  logic               busy_q, busy_d;
  logic               q_full_q, q_full_d;
  logic [2:0]         sold_out_q, sold_out_d;
  logic               drop_err_q, drop_err_d;

`ifdef VM_DISP_TIMEOUT_EN
  localparam logic [7:0] TMR_MAX = 8'(TIMEOUT);
  logic [7:0] tmr_q, tmr_d;
  logic       fault_q, fault_d;
`endif

  logic               push_req, push, pop, multi, ovf;
  logic [1:0]         req_prod;
  logic [2:0]         head;
  logic [STOCK_W-1:0] head_stock;

  always_comb begin
    state_d    = state_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    job_d      = job_q;
    chg_pend_d = chg_pend_q;
    stock_d    = stock_q;
    mtr_sel_d  = mtr_sel_q;
`ifdef VM_DISP_TIMEOUT_EN
    tmr_d      = tmr_q;
`endif

    // Request encoding: A beats B beats C; every losing product is a drop.
    multi    = (req_a & (req_b | req_c)) | (req_b & req_c);
    req_prod = req_a ? 2'd0 : req_b ? 2'd1 : req_c ? 2'd2 : 2'd3;
    push_req = req_a | req_b | req_c | req_chg;
    pop      = (state_q == S_LOAD);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    push     = push_req & ((count_q != 3'd4) | pop);
    ovf      = push_req & (count_q == 3'd4) & ~pop;

    if (push) begin
      fifo_d[wr_ptr_q] = {req_chg, req_prod};
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    count_d = count_q + {2'b00, push} - {2'b00, pop};

    head       = fifo_q[rd_ptr_q];
    head_stock = '0;
    for (int i = 0; i < 3; i++) begin
      if (head[1:0] == 2'(i)) head_stock = stock_q[i];
    end

    case (state_q)
      S_IDLE: begin
        if (count_q != 3'd0) state_d = S_LOAD;
      end
      S_LOAD: begin
        job_d = head;
        if (head[1:0] != 2'd3 && head_stock != '0) begin
          state_d   = S_PROD;
          mtr_sel_d = head[1:0];
        end else if (head[1:0] != 2'd3 || head[2]) begin
          // Either a plain change request or a sold-out vend turned into a refund.
          state_d   = S_CHG;
          mtr_sel_d = 2'd3;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PROD: begin
        if (mtr_done) begin
          for (int i = 0; i < 3; i++) begin
            if (job_q[1:0] == 2'(i) && stock_q[i] != '0)
              stock_d[i] = stock_q[i] - STOCK_W'(1);
          end
          chg_pend_d = job_q[2];
          state_d    = S_RELEASE;
        end
`ifdef VM_DISP_TIMEOUT_EN
        else if (tmr_q == TMR_MAX) state_d = S_FAULT;
        else tmr_d = tmr_q + 8'd1;
`endif
      end
      S_CHG: begin
        if (mtr_done) begin
          chg_pend_d = 1'b0;
          state_d    = S_RELEASE;
        end
`ifdef VM_DISP_TIMEOUT_EN
        else if (tmr_q == TMR_MAX) state_d = S_FAULT;
        else tmr_d = tmr_q + 8'd1;
`endif
      end
      S_RELEASE: begin
        if (!mtr_done) begin
          if (chg_pend_q) begin
            state_d   = S_CHG;
            mtr_sel_d = 2'd3;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_FAULT: begin
        if (fault_clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef VM_DISP_TIMEOUT_EN
    if ((state_d == S_PROD || state_d == S_CHG) && state_d != state_q) tmr_d = '0;
    fault_d = (state_d == S_FAULT);
`endif

    // Restock is applied last so it overrides a same-cycle decrement.
    if (restock) begin
      for (int i = 0; i < 3; i++) stock_d[i] = STOCK_LD;
    end
    for (int i = 0; i < 3; i++) sold_out_d[i] = (stock_d[i] == '0);

    mtr_en_d   = (state_d == S_PROD) || (state_d == S_CHG);
    busy_d     = (state_d != S_IDLE);
    q_full_d   = (count_d == 3'd4);
    drop_err_d = multi | ovf;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      job_q      <= '0;
      chg_pend_q <= 1'b0;
      for (int i = 0; i < 3; i++) stock_q[i] <= STOCK_LD;
      mtr_en_q   <= 1'b0;
      mtr_sel_q  <= 2'd0;
      busy_q     <= 1'b0;
      q_full_q   <= 1'b0;
      sold_out_q <= 3'b000;
      drop_err_q <= 1'b0;
`ifdef VM_DISP_TIMEOUT_EN
      tmr_q      <= '0;
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      job_q      <= job_d;
      chg_pend_q <= chg_pend_d;
      stock_q    <= stock_d;
      mtr_en_q   <= mtr_en_d;
      mtr_sel_q  <= mtr_sel_d;
      busy_q     <= busy_d;
      q_full_q   <= q_full_d;
      sold_out_q <= sold_out_d;
      drop_err_q <= drop_err_d;
`ifdef VM_DISP_TIMEOUT_EN
      tmr_q      <= tmr_d;
      fault_q    <= fault_d;
`endif
    end
  end

  assign mtr_en   = mtr_en_q;
  assign mtr_sel  = mtr_sel_q;
  assign busy     = busy_q;
  assign q_full   = q_full_q;
  assign sold_out = sold_out_q;
  assign drop_err = drop_err_q;
`ifdef VM_DISP_TIMEOUT_EN
  assign fault    = fault_q;
`else
  assign fault    = 1'b0;
`endif

endmodule

// File: tb/tb_vm_dispense_ctrl.sv
// Bench for vm_dispense_ctrl: table-driven request vectors plus hand-written
// sequences. Expected motor commands are pushed to a queue when a request is
// driven and popped when the DUT raises mtr_en.

module tb_vm_dispense_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0, req_c = 1'b0, req_chg = 1'b0;
  logic       restock = 1'b0, fault_clr = 1'b0, mtr_done = 1'b0;
  logic       mtr_en, busy, q_full, drop_err, fault;
  logic [1:0] mtr_sel;
  logic [2:0] sold_out;

  vm_dispense_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_chg(req_chg),
    .restock(restock), .fault_clr(fault_clr), .mtr_done(mtr_done),
    .mtr_en(mtr_en), .mtr_sel(mtr_sel), .busy(busy), .q_full(q_full),
    .sold_out(sold_out), .drop_err(drop_err), .fault(fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q [$];
  int         m_stock [3];

  // Motor driver model
  int dly = 3;
  bit stall = 1'b0;
  int rcnt = 0;

  // Command monitor state
  logic       en_prev = 1'b0;
  logic [1:0] cur_sel = 2'd0;
  int         hi_len = 0;
  int         last_len = 0;

  typedef struct {
    logic  a, b, c, chg;
    logic  exp_drop;
    string nm;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  function automatic logic [2:0] m_sold();
    return {m_stock[2] == 0, m_stock[1] == 0, m_stock[0] == 0};
  endfunction

  // Reference model of one accepted request: product first (or refund), then change.
  task automatic model_push(input logic a, b, c, chg);
    int p;
    p = a ? 0 : b ? 1 : c ? 2 : 3;
    if (p != 3) begin
      if (m_stock[p] > 0) begin
        exp_q.push_back(2'(p));
        m_stock[p]--;
        if (chg) exp_q.push_back(2'd3);
      end else begin
        exp_q.push_back(2'd3);
      end
    end else if (chg) begin
      exp_q.push_back(2'd3);
    end
  endtask

  task automatic send(input logic a, b, c, chg, input logic exp_drop,
                      input bit accepted, input string nm);
    @(negedge clk);
    req_a = a; req_b = b; req_c = c; req_chg = chg;
    if (accepted) model_push(a, b, c, chg);
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0; req_c = 1'b0; req_chg = 1'b0;
    chk({nm, "_drop_err"}, drop_err, exp_drop);
  endtask

  task automatic wait_idle(input string nm);
    int idle = 0;
    int n = 0;
    while (idle < 3 && n < 3000) begin
      @(negedge clk);
      if (!busy) idle++; else idle = 0;
      n++;
    end
    if (idle < 3) timeout_fail({nm, "_idle"});
  endtask

  task automatic wait_en(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mtr_en && n < 200);
    if (!mtr_en) timeout_fail({nm, "_mtr_en"});
  endtask

  always @(negedge clk) begin
    if (!mtr_en) begin
      rcnt = 0;
      mtr_done = 1'b0;
    end else if (!stall) begin
      rcnt++;
      if (rcnt >= dly + 1) mtr_done = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (mtr_en && !en_prev) begin
      hi_len = 1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmd: got sel %0h expected no command", mtr_sel);
      end else begin
        cur_sel = exp_q.pop_front();
        chk("cmd_sel", mtr_sel, cur_sel);
      end
    end else if (mtr_en) begin
      hi_len++;
      chk("sel_stable", mtr_sel, cur_sel);
    end else if (en_prev) begin
      last_len = hi_len;
    end
    en_prev = mtr_en;
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "a_chg"};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "a_b"};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "b_c_chg"};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "chg_only"};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "a_b_c"};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "c_only"};
    for (int i = 0; i < 3; i++) m_stock[i] = 8;

    // Reset values
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_mtr_en", mtr_en, 1'b0);
    chk("rst_mtr_sel", mtr_sel, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_q_full", q_full, 1'b0);
    chk("rst_drop_err", drop_err, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_sold_out", sold_out, 3'b000);

    // Single B vend: latency, 4-cycle command, stock 8 -> 7
    dly = 3;
    send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "vend_b");
    chk("vend_b_busy_load", busy, 1'b0);
    @(negedge clk);
    chk("vend_b_en_k1", mtr_en, 1'b0);
    chk("vend_b_busy_k1", busy, 1'b1);
    @(negedge clk);
    chk("vend_b_en_k2", mtr_en, 1'b1);
    chk("vend_b_sel", mtr_sel, 2'd1);
    wait_idle("vend_b");
    chk("vend_b_len", last_len, 4);
    chk("vend_b_stock", dut.stock_q[1], 7);
    chk("vend_b_busy_end", busy, 1'b0);

    // Table of request combinations
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].chg, tbl[i].exp_drop, 1'b1, tbl[i].nm);
      wait_idle(tbl[i].nm);
      chk({tbl[i].nm, "_sold_out"}, sold_out, m_sold());
      chk({tbl[i].nm, "_q_empty"}, exp_q.size(), 0);
    end
    chk("a_chg_stock_a", dut.stock_q[0], m_stock[0]);

    // Restock, then drain C and request a 9th C (refund only)
    @(negedge clk);
    restock = 1'b1;
    @(negedge clk);
    restock = 1'b0;
    for (int i = 0; i < 3; i++) m_stock[i] = 8;
    chk("restock_sold_out", sold_out, 3'b000);
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "drain_c");
      wait_idle("drain_c");
    end
    chk("drain_c_sold_out", sold_out, 3'b100);
    send(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "refund_c");
    wait_idle("refund_c");
    chk("refund_c_stock", dut.stock_q[2], 0);
    chk("refund_c_sold_out", sold_out, 3'b100);
    chk("refund_c_q_empty", exp_q.size(), 0);

    // Stalled motor fills the FIFO; the 5th queued pulse is dropped
    stall = 1'b1;
    send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "stall_job0");
    wait_en("stall_job0");
    for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "fill");
    chk("fill_q_full", q_full, 1'b1);
    send(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "overflow");
    chk("overflow_q_full", q_full, 1'b1);

`ifdef VM_DISP_TIMEOUT_EN
    begin
      int n = 0;
      while (!fault && n < 600) begin
        @(negedge clk);
        n++;
      end
      if (!fault) timeout_fail("timeout_fault");
    end
    @(negedge clk);
    chk("timeout_fault", fault, 1'b1);
    chk("timeout_mtr_en", mtr_en, 1'b0);
    chk("timeout_len_ok", (last_len >= 255 && last_len <= 256), 1'b1);
    m_stock[0]++;
    stall = 1'b0;
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("fault_clr", fault, 1'b0);
    wait_idle("resume");
    chk("resume_q_empty", exp_q.size(), 0);
    chk("resume_stock_a", dut.stock_q[0], m_stock[0]);
`else
    repeat (300) @(negedge clk);
    chk("no_timeout_fault", fault, 1'b0);
    chk("no_timeout_mtr_en", mtr_en, 1'b1);
    stall = 1'b0;
    wait_idle("unstall");
    chk("unstall_q_empty", exp_q.size(), 0);
    chk("unstall_stock_a", dut.stock_q[0], m_stock[0]);
`endif

    // Restock on the same edge as a B decrement
    send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "collide");
    wait_en("collide");
    repeat (3) @(negedge clk);
    restock = 1'b1;
    @(negedge clk);
    restock = 1'b0;
    for (int i = 0; i < 3; i++) m_stock[i] = 8;
    wait_idle("collide");
    chk("collide_stock_b", dut.stock_q[1], 8);
    chk("collide_sold_out", sold_out, 3'b000);

    // Reset in the middle of a dispense
    stall = 1'b1;
    send(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "midrst");
    wait_en("midrst");
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < 3; i++) m_stock[i] = 8;
    chk("midrst_mtr_en", mtr_en, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_stock_c", dut.stock_q[2], 8);
    repeat (5) @(negedge clk);
    chk("midrst_idle", busy, 1'b0);
    chk("final_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
